// File: rtl/fifo_mon_pkg.sv
// Shared constants and types for the FIFO occupancy monitor.
// Slot map: 0=main, 1=VC0, 2=VC1, 3=D0, 4=D1.
package fifo_mon_pkg;

   localparam int NUM_FIFOS_DEF = 5;
   localparam int CNT_W_DEF     = 5;
   localparam int DEPTH_DEF     = 16;

   localparam int SLOT_MAIN = 0;
   localparam int SLOT_VC0  = 1;
   localparam int SLOT_VC1  = 2;
   localparam int SLOT_D0   = 3;
   localparam int SLOT_D1   = 4;

   // Thresholds after reset: low=0, high=DEPTH.
   localparam int TH_LOW_RST  = 0;
   localparam int TH_HIGH_RST = DEPTH_DEF;

   // Strobe combination seen by one counter, encoded {pop, push}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

endpackage

// File: rtl/fifo_occ_cnt.sv
// One saturating occupancy counter with watermark compare and error flag.
// Ports: clk, reset (sync, active-high), push_i/pop_i strobes,
// th_low_i/th_high_i next-state thresholds, registered cnt_o and flags.
// Macro FIFO_MON_STICKY_ERR_EN: err_o holds until reset when defined,
// otherwise it is a one-cycle pulse after the offending strobe.
module fifo_occ_cnt
   import fifo_mon_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [CNT_W-1:0] th_low_i,
   input  logic [CNT_W-1:0] th_high_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             aempty_o,
   output logic             afull_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             empty_q, full_q;
   logic             aempty_q, afull_q;
   logic             err_q, err_d;
   logic             evt;
   op_e              op;

   always_comb begin
      op    = op_e'({pop_i, push_i});
      cnt_d = cnt_q;
      evt   = 1'b0;
      unique case (op)
         OP_PUSH: begin
            if (cnt_q == DEPTH_C) evt = 1'b1;
            else cnt_d = cnt_q + 1'b1;
         end
         OP_POP: begin
            if (cnt_q == '0) evt = 1'b1;
            else cnt_d = cnt_q - 1'b1;
         end
         OP_BOTH: begin
            // Read of an empty FIFO still underflows;
            // the write lands, leaving one entry.
            if (cnt_q == '0) begin
               evt   = 1'b1;
               cnt_d = CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

`ifdef FIFO_MON_STICKY_ERR_EN
   assign err_d = err_q | evt;
`else
   assign err_d = evt;
`endif

   // Flags are derived from next-state values so they
   // line up with cnt_o in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         empty_q  <= (cnt_d == '0);
         full_q   <= (cnt_d == DEPTH_C);
         aempty_q <= (cnt_d <= th_low_i);
         afull_q  <= (cnt_d >= th_high_i);
         err_q    <= err_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign empty_o  = empty_q;
   assign full_o   = full_q;
   assign aempty_o = aempty_q;
   assign afull_o  = afull_q;
   assign err_o    = err_q;

endmodule

// File: rtl/fifo_status_monitor.sv
// Occupancy/watermark monitor for the main, VC0, VC1, D0, D1 FIFOs.
// Ports: clk, reset (sync, active-high), cfg_load + th_low/th_high
// packed threshold buses, push/pop strobes; outputs empties, full,
// almost_empty, almost_full, errors, packed occupancy (all registered).
// Error behaviour selected by macro FIFO_MON_STICKY_ERR_EN.
module fifo_status_monitor
   import fifo_mon_pkg::*;
#(
   parameter int NUM_FIFOS = NUM_FIFOS_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_load,
   input  logic [NUM_FIFOS*CNT_W-1:0] th_low,
   input  logic [NUM_FIFOS*CNT_W-1:0] th_high,
   input  logic [NUM_FIFOS-1:0]       push,
   input  logic [NUM_FIFOS-1:0]       pop,
   output logic [NUM_FIFOS-1:0]       empties,
   output logic [NUM_FIFOS-1:0]       full,
   output logic [NUM_FIFOS-1:0]       almost_empty,
   output logic [NUM_FIFOS-1:0]       almost_full,
   output logic [NUM_FIFOS-1:0]       errors,
   output logic [NUM_FIFOS*CNT_W-1:0] occupancy
);

   localparam int BW = NUM_FIFOS * CNT_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LOW_R   = CNT_W'(TH_LOW_RST);
   localparam logic [BW-1:0] TH_LOW_R   = {NUM_FIFOS{LOW_R}};
   localparam logic [BW-1:0] TH_HIGH_R  = {NUM_FIFOS{DEPTH_C}};

   logic [BW-1:0] th_low_q, th_low_d;
   logic [BW-1:0] th_high_q, th_high_d;

   for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_slot
      logic [CNT_W-1:0] lo_in, hi_in;
      logic [CNT_W-1:0] lo_cl, hi_cl;

      assign lo_in = th_low[i*CNT_W +: CNT_W];
      assign hi_in = th_high[i*CNT_W +: CNT_W];
      // Clamp on capture so stored values never exceed DEPTH.
      assign lo_cl = (lo_in > DEPTH_C) ? DEPTH_C : lo_in;
      assign hi_cl = (hi_in > DEPTH_C) ? DEPTH_C : hi_in;

      assign th_low_d[i*CNT_W +: CNT_W] =
         cfg_load ? lo_cl : th_low_q[i*CNT_W +: CNT_W];
      assign th_high_d[i*CNT_W +: CNT_W] =
         cfg_load ? hi_cl : th_high_q[i*CNT_W +: CNT_W];

      fifo_occ_cnt #(
         .DEPTH (DEPTH),
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .push_i    (push[i]),
         .pop_i     (pop[i]),
         .th_low_i  (th_low_d[i*CNT_W +: CNT_W]),
         .th_high_i (th_high_d[i*CNT_W +: CNT_W]),
         .cnt_o     (occupancy[i*CNT_W +: CNT_W]),
         .empty_o   (empties[i]),
         .full_o    (full[i]),
         .aempty_o  (almost_empty[i]),
         .afull_o   (almost_full[i]),
         .err_o     (errors[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         th_low_q  <= TH_LOW_R;
         th_high_q <= TH_HIGH_R;
      end else begin
         th_low_q  <= th_low_d;
         th_high_q <= th_high_d;
      end
   end

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Self-checking bench for fifo_status_monitor: vector table,
// directed corner sequences and randomized traffic vs a reference model.
module tb_fifo_status_monitor;

   localparam int N = 5;
   localparam int W = 5;
   localparam int D = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           cfg_load;
   logic [N*W-1:0] th_low, th_high;
   logic [N-1:0]   push, pop;
   logic [N-1:0]   empties, full, almost_empty, almost_full, errors;
   logic [N*W-1:0] occupancy;

   always #5 clk = ~clk;

   fifo_status_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_load     (cfg_load),
      .th_low       (th_low),
      .th_high      (th_high),
      .push         (push),
      .pop          (pop),
      .empties      (empties),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .errors       (errors),
      .occupancy    (occupancy)
   );

   int vectors = 0;
   int miscompares = 0;

`ifdef FIFO_MON_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   // Reference model state: plain integers per slot.
   int m_cnt[N];
   int m_lo[N];
   int m_hi[N];
   bit m_err[N];

   typedef struct {
      logic           rst;
      logic           cfg;
      logic [N*W-1:0] lo;
      logic [N*W-1:0] hi;
      logic [N-1:0]   psh;
      logic [N-1:0]   pp;
      logic [N*W-1:0] e_occ;
      logic [N-1:0]   e_emp;
      logic [N-1:0]   e_full;
      logic [N-1:0]   e_ae;
      logic [N-1:0]   e_af;
      logic [N-1:0]   e_err;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_step(
      logic rst, logic cfg,
      logic [N*W-1:0] lo, logic [N*W-1:0] hi,
      logic [N-1:0] psh, logic [N-1:0] pp);
      for (int i = 0; i < N; i++) begin
         bit bad;
         int l, h;
         bad = 1'b0;
         if (rst) begin
            m_cnt[i] = 0;
            m_lo[i]  = 0;
            m_hi[i]  = D;
            m_err[i] = 1'b0;
         end else begin
            if (cfg) begin
               l = int'(lo[i*W +: W]);
               h = int'(hi[i*W +: W]);
               m_lo[i] = (l > D) ? D : l;
               m_hi[i] = (h > D) ? D : h;
            end
            if (pp[i] && m_cnt[i] == 0) begin
               bad = 1'b1;
               m_cnt[i] += int'(psh[i]);
            end else if (psh[i] && !pp[i] && m_cnt[i] == D) begin
               bad = 1'b1;
            end else begin
               m_cnt[i] += int'(psh[i]) - int'(pp[i]);
            end
            m_err[i] = STICKY ? (m_err[i] | bad) : bad;
         end
      end
   endfunction

   task automatic check_model(string tag);
      logic [N*W-1:0] eo;
      logic [N-1:0] ee, ef, ea, eh, er;
      for (int i = 0; i < N; i++) begin
         eo[i*W +: W] = W'(m_cnt[i]);
         ee[i] = (m_cnt[i] == 0);
         ef[i] = (m_cnt[i] == D);
         ea[i] = (m_cnt[i] <= m_lo[i]);
         eh[i] = (m_cnt[i] >= m_hi[i]);
         er[i] = m_err[i];
      end
      chk({tag, ".occ"}, 32'(occupancy), 32'(eo));
      chk({tag, ".empties"}, 32'(empties), 32'(ee));
      chk({tag, ".full"}, 32'(full), 32'(ef));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(ea));
      chk({tag, ".afull"}, 32'(almost_full), 32'(eh));
      chk({tag, ".errors"}, 32'(errors), 32'(er));
   endtask

   task automatic apply(
      logic rst, logic cfg,
      logic [N*W-1:0] lo, logic [N*W-1:0] hi,
      logic [N-1:0] psh, logic [N-1:0] pp);
      reset    = rst;
      cfg_load = cfg;
      th_low   = lo;
      th_high  = hi;
      push     = psh;
      pop      = pp;
      @(posedge clk);
      #1;
      model_step(rst, cfg, lo, hi, psh, pp);
   endtask

   initial begin
      logic [N*W-1:0] lo_main, hi_main, hi_vc1;
      logic [N*W-1:0] rlo, rhi;
      logic [N-1:0]   rp, rq;
      int             r;
      bit             rr, rc;

      reset    = 1'b1;
      cfg_load = 1'b0;
      th_low   = '0;
      th_high  = '0;
      push     = '0;
      pop      = '0;

      lo_main = {5'd0, 5'd0, 5'd0, 5'd0, 5'd2};
      hi_main = {5'd16, 5'd16, 5'd16, 5'd16, 5'd12};
      hi_vc1  = {5'd16, 5'd16, 5'd20, 5'd16, 5'd12};

      // Reset, 3 idle cycles, threshold load, 12 pushes to main.
      for (int k = 0; k < 17; k++) begin
         tbl[k].rst    = (k == 0);
         tbl[k].cfg    = (k == 4);
         tbl[k].lo     = lo_main;
         tbl[k].hi     = hi_main;
         tbl[k].psh    = (k >= 5) ? 5'b00001 : 5'b00000;
         tbl[k].pp     = '0;
         tbl[k].e_occ  = '0;
         tbl[k].e_emp  = 5'b11111;
         tbl[k].e_full = '0;
         tbl[k].e_ae   = 5'b11111;
         tbl[k].e_af   = '0;
         tbl[k].e_err  = '0;
         if (k >= 5) begin
            tbl[k].e_occ[4:0] = 5'(k - 4);
            tbl[k].e_emp      = 5'b11110;
            tbl[k].e_ae       = (k - 4 <= 2) ? 5'b11111 : 5'b11110;
            tbl[k].e_af       = (k - 4 >= 12) ? 5'b00001 : 5'b00000;
         end
      end

      for (int k = 0; k < 17; k++) begin
         apply(tbl[k].rst, tbl[k].cfg, tbl[k].lo, tbl[k].hi,
               tbl[k].psh, tbl[k].pp);
         chk($sformatf("tbl%0d.occ", k), 32'(occupancy), 32'(tbl[k].e_occ));
         chk($sformatf("tbl%0d.emp", k), 32'(empties), 32'(tbl[k].e_emp));
         chk($sformatf("tbl%0d.full", k), 32'(full), 32'(tbl[k].e_full));
         chk($sformatf("tbl%0d.ae", k), 32'(almost_empty), 32'(tbl[k].e_ae));
         chk($sformatf("tbl%0d.af", k), 32'(almost_full), 32'(tbl[k].e_af));
         chk($sformatf("tbl%0d.err", k), 32'(errors), 32'(tbl[k].e_err));
      end

      // VC0: fill to DEPTH, overflow, then simultaneous push+pop.
      for (int k = 0; k < 16; k++) begin
         apply(0, 0, '0, '0, 5'b00010, 5'b00000);
         check_model("vc0_fill");
      end
      apply(0, 0, '0, '0, 5'b00010, 5'b00000);
      check_model("vc0_ovf");
      chk("vc0_ovf_err", 32'(errors[1]), 32'd1);
      chk("vc0_ovf_occ", 32'(occupancy[5 +: 5]), 32'd16);
      apply(0, 0, '0, '0, 5'b00010, 5'b00010);
      check_model("vc0_rw");
      chk("vc0_rw_occ", 32'(occupancy[5 +: 5]), 32'd16);
      chk("vc0_rw_err", 32'(errors[1]), 32'(STICKY));

      // D1: push+pop while empty.
      apply(0, 0, '0, '0, 5'b10000, 5'b10000);
      check_model("d1_unf");
      chk("d1_unf_err", 32'(errors[4]), 32'd1);
      chk("d1_unf_occ", 32'(occupancy[20 +: 5]), 32'd1);
      chk("d1_unf_emp", 32'(empties[4]), 32'd0);
      for (int k = 0; k < 2; k++) begin
         apply(0, 0, '0, '0, 5'b00000, 5'b00000);
         check_model("d1_after");
         chk($sformatf("d1_after%0d_err", k), 32'(errors[4]), 32'(STICKY));
      end

      // VC1: high threshold 20 clamps to 16.
      apply(0, 1, lo_main, hi_vc1, 5'b00000, 5'b00000);
      check_model("vc1_cfg");
      for (int k = 1; k <= 16; k++) begin
         apply(0, 0, '0, '0, 5'b00100, 5'b00000);
         check_model("vc1_fill");
         chk($sformatf("vc1_full%0d", k), 32'(full[2]), 32'(k == 16));
         chk($sformatf("vc1_af%0d", k), 32'(almost_full[2]), 32'(k == 16));
      end

      // Reset wins over cfg_load and push.
      apply(1, 1, {N{5'd3}}, {N{5'd5}}, 5'b11111, 5'b00000);
      check_model("rst_pri");
      chk("rst_pri_occ", 32'(occupancy), 32'd0);
      chk("rst_pri_emp", 32'(empties), 32'h1f);
      chk("rst_pri_ae", 32'(almost_empty), 32'h1f);
      apply(0, 0, '0, '0, 5'b11111, 5'b00000);
      check_model("rst_thr");
      chk("rst_thr_ae", 32'(almost_empty), 32'd0);
      chk("rst_thr_af", 32'(almost_full), 32'd0);

      // Randomized traffic: push-heavy first half, pop-heavy second.
      for (int k = 0; k < 600; k++) begin
         r  = int'($urandom_range(0, 199));
         rr = (r == 0);
         rc = (r > 0 && r < 10);
         for (int i = 0; i < N; i++) begin
            rlo[i*W +: W] = W'($urandom_range(0, 31));
            rhi[i*W +: W] = W'($urandom_range(0, 31));
         end
         if (k < 300) begin
            rp = N'($urandom);
            rq = N'($urandom) & N'($urandom);
         end else begin
            rp = N'($urandom) & N'($urandom);
            rq = N'($urandom);
         end
         apply(rr, rc, rlo, rhi, rp, rq);
         check_model("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
